dec_gpr_wb_arb: RTL and testbench

Writeback arbiter and pending-write scoreboard placed directly upstream of the integer/FP general-purpose register file (`dec_gpr_ctl`). It merges two result producers, the load path (LSU) and the FPU, onto the register file's single write port (`wen0`/`waddr0`/`wd0`). FPU results pass through a small skid FIFO. A 32-bit busy vector tells the decode stage which destination registers still have a write in flight.

---
 rtl/dec_pkg.sv | 19 +
 rtl/dec_wb_fifo.sv | 54 +++++
 rtl/dec_gpr_wb_arb.sv | 125 ++++++++++++
 tb/tb_dec_gpr_wb_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared decode-stage definitions for the register-file writeback path.
package dec_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned NUM_GPR = 32;
  localparam int unsigned WB_XLEN = 32;

  // Result bus at the default datapath width: destination plus data.
  typedef struct packed {
    logic [REG_AW-1:0]  rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

  // x0 is hardwired to zero: never written, never tracked as busy.
  function automatic logic is_x0(input logic [REG_AW-1:0] rd);
    return rd == '0;
  endfunction

endpackage

// File: rtl/dec_wb_fifo.sv
// Generic synchronous FIFO with registered pointers and an occupancy count.
// Head data is presented combinationally from the read pointer.
module dec_wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow so callers cannot corrupt state.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Pointer and count update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dec_gpr_wb_arb.sv
// Writeback arbiter in front of the GPR file: merges LSU and queued FPU
// results onto one registered write port and tracks pending writes.
module dec_gpr_wb_arb
  import dec_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [4:0]        lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              fpu_valid,
  output logic              fpu_ready,
  input  logic [4:0]        fpu_rd,
  input  logic [XLEN-1:0]   fpu_data,
  output logic              wen0,
  output logic [4:0]        waddr0,
  output logic [XLEN-1:0]   wd0,
  output logic [31:0]       busy
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int unsigned EW = REG_AW + XLEN;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_bus_t;

  wb_bus_t            fpu_in;
  wb_bus_t            fifo_head;
  wb_bus_t            win;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_prio;
  logic               grant_lsu;
  logic               grant_fifo;
  logic [SW-1:0]      starve_cnt;
  logic [SW-1:0]      starve_cnt_d;
  logic [NUM_GPR-1:0] busy_q;
  logic [NUM_GPR-1:0] busy_d;

  assign fpu_in    = {fpu_rd, fpu_data};
  // No pass-through: a full FIFO refuses even in a cycle where it pops.
  assign fpu_ready = !fifo_full && !rst;
  assign fifo_push = fpu_valid && fpu_ready;

  dec_wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fpu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (grant_fifo),
    .wdata (fpu_in),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Arbitration: LSU first unless the FIFO head has lost STARVE_MAX times in a row.
  always_comb begin
    fifo_prio  = (starve_cnt == SW'(STARVE_MAX));
    grant_fifo = !rst && !fifo_empty && (fifo_prio || !lsu_valid);
    grant_lsu  = !rst && lsu_valid && !grant_fifo;
    win        = grant_fifo ? fifo_head : wb_bus_t'({lsu_rd, lsu_data});
    lsu_ready  = grant_lsu;
  end

  // Starvation count of consecutive LSU wins over a waiting FIFO head.
  always_comb begin
    starve_cnt_d = starve_cnt;
    if (fifo_empty || grant_fifo) begin
      starve_cnt_d = '0;
    end else if (grant_lsu && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt + SW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_cnt <= '0;
    else     starve_cnt <= starve_cnt_d;
  end

  // Registered write port; x0 results complete the handshake but never write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen0   <= 1'b0;
      waddr0 <= '0;
      wd0    <= '0;
    end else if (grant_lsu || grant_fifo) begin
      wen0   <= !is_x0(win.rd);
      waddr0 <= win.rd;
      wd0    <= win.data;
    end else begin
      wen0   <= 1'b0;
    end
  end

  // Scoreboard next state: clear on the writing edge, then set so a new issue wins.
  always_comb begin
    busy_d = busy_q;
    if (wen0) busy_d[waddr0] = 1'b0;
    if (issue_valid && !is_x0(issue_rd)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_dec_gpr_wb_arb.sv
// Directed bench for the writeback arbiter and scoreboard.
module tb_dec_gpr_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_data;
  logic        wen0;
  logic [4:0]  waddr0;
  logic [31:0] wd0;
  logic [31:0] busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dec_gpr_wb_arb #(
    .XLEN       (32),
    .FIFO_DEPTH (2),
    .STARVE_MAX (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .fpu_valid   (fpu_valid),
    .fpu_ready   (fpu_ready),
    .fpu_rd      (fpu_rd),
    .fpu_data    (fpu_data),
    .wen0        (wen0),
    .waddr0      (waddr0),
    .wd0         (wd0),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; issue_valid = 1'b0; issue_rd = '0;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h4444;
    fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_data = 32'h3333;
    settle();
    n_cmp++; if (fpu_ready !== 1'b0) begin n_err++; $display("FAIL rst_fpu_ready got %b want 0", fpu_ready); end
    n_cmp++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL rst_lsu_ready got %b want 0", lsu_ready); end
    tick();
    n_cmp++; if (wen0 !== 1'b0) begin n_err++; $display("FAIL rst_wen0 got %b want 0", wen0); end
    n_cmp++; if (busy !== 32'h0) begin n_err++; $display("FAIL rst_busy got %h want 0", busy); end
    n_cmp++; if (waddr0 !== 5'd0 || wd0 !== 32'h0) begin
      n_err++; $display("FAIL rst_wport got %0d/%h want 0/0", waddr0, wd0);
    end
    tick();
    n_cmp++; if (fpu_ready !== 1'b0 || wen0 !== 1'b0) begin
      n_err++; $display("FAIL rst_hold got ready=%b wen=%b want 0/0", fpu_ready, wen0);
    end
    rst = 1'b0; fpu_valid = 1'b0; lsu_valid = 1'b0;
    settle();
    n_cmp++; if (fpu_ready !== 1'b1) begin n_err++; $display("FAIL rel_fpu_ready got %b want 1", fpu_ready); end
    n_cmp++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL rel_lsu_ready got %b want 0", lsu_ready); end
  endtask

  task automatic test_single_fpu();
    tick();
    issue_valid = 1'b1; issue_rd = 5'd5;
    fpu_valid = 1'b1; fpu_rd = 5'd5; fpu_data = 32'h3F80_0000;
    settle();
    tick();
    issue_valid = 1'b0; fpu_valid = 1'b0;
    settle();
    n_cmp++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL sfpu_lsu_ready got %b want 0", lsu_ready); end
    n_cmp++; if (busy !== 32'h20) begin n_err++; $display("FAIL sfpu_busy_set got %h want 00000020", busy); end
    n_cmp++; if (wen0 !== 1'b0) begin n_err++; $display("FAIL sfpu_wen_early got %b want 0", wen0); end
    tick();
    n_cmp++; if (wen0 !== 1'b1 || waddr0 !== 5'd5 || wd0 !== 32'h3F80_0000) begin
      n_err++; $display("FAIL sfpu_write got %b/%0d/%h want 1/5/3f800000", wen0, waddr0, wd0);
    end
    n_cmp++; if (busy !== 32'h20) begin n_err++; $display("FAIL sfpu_busy_hold got %h want 00000020", busy); end
    tick();
    n_cmp++; if (wen0 !== 1'b0 || busy !== 32'h0) begin
      n_err++; $display("FAIL sfpu_done got wen=%b busy=%h want 0/0", wen0, busy);
    end
  endtask

  task automatic test_contention();
    // C0: FIFO empty, LSU takes the port while F0 is queued.
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hA000_0000;
    fpu_valid = 1'b1; fpu_rd = 5'd9; fpu_data = 32'hF000_0000;
    settle();
    n_cmp++; if (lsu_ready !== 1'b1 || fpu_ready !== 1'b1) begin
      n_err++; $display("FAIL cont_c0 got lsu=%b fpu=%b want 1/1", lsu_ready, fpu_ready);
    end
    // C1..C3: LSU keeps winning; FIFO fills and stops accepting.
    for (int i = 1; i <= 3; i++) begin
      tick();
      lsu_data = 32'hA000_0000 + i;
      fpu_data = 32'hF000_0000 + ((i > 1) ? 2 : 1);
      settle();
      n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL cont_lsu_win%0d got %b want 1", i, lsu_ready); end
      n_cmp++; if (fpu_ready !== (i == 1)) begin
        n_err++; $display("FAIL cont_fpu_ready%0d got %b want %b", i, fpu_ready, (i == 1));
      end
      n_cmp++; if (wen0 !== 1'b1 || waddr0 !== 5'd7 || wd0 !== 32'hA000_0000 + i - 1) begin
        n_err++; $display("FAIL cont_wr%0d got %b/%0d/%h want 1/7/%h", i, wen0, waddr0, wd0, 32'hA000_0000 + i - 1);
      end
    end
    // C4: starved FIFO head takes priority; LSU must hold its data.
    tick();
    lsu_data = 32'hA000_0004;
    settle();
    n_cmp++; if (lsu_ready !== 1'b0 || fpu_ready !== 1'b0) begin
      n_err++; $display("FAIL cont_starve got lsu=%b fpu=%b want 0/0", lsu_ready, fpu_ready);
    end
    n_cmp++; if (wd0 !== 32'hA000_0003) begin n_err++; $display("FAIL cont_wr4 got %h want a0000003", wd0); end
    // C5: F0 written; F2 pushed now that a slot opened; LSU wins again.
    tick();
    settle();
    n_cmp++; if (wen0 !== 1'b1 || waddr0 !== 5'd9 || wd0 !== 32'hF000_0000) begin
      n_err++; $display("FAIL cont_fpu_wr got %b/%0d/%h want 1/9/f0000000", wen0, waddr0, wd0);
    end
    n_cmp++; if (lsu_ready !== 1'b1 || fpu_ready !== 1'b1) begin
      n_err++; $display("FAIL cont_c5 got lsu=%b fpu=%b want 1/1", lsu_ready, fpu_ready);
    end
    tick();
    fpu_valid = 1'b0; lsu_valid = 1'b0;
    settle();
    n_cmp++; if (wd0 !== 32'hA000_0004 || waddr0 !== 5'd7) begin
      n_err++; $display("FAIL cont_l4 got %0d/%h want 7/a0000004", waddr0, wd0);
    end
    tick();
    n_cmp++; if (wd0 !== 32'hF000_0001 || waddr0 !== 5'd9 || wen0 !== 1'b1) begin
      n_err++; $display("FAIL cont_f1 got %b/%0d/%h want 1/9/f0000001", wen0, waddr0, wd0);
    end
    tick();
    n_cmp++; if (wd0 !== 32'hF000_0002 || wen0 !== 1'b1) begin
      n_err++; $display("FAIL cont_f2 got %b/%h want 1/f0000002", wen0, wd0);
    end
    tick();
    n_cmp++; if (wen0 !== 1'b0 || wd0 !== 32'hF000_0002) begin
      n_err++; $display("FAIL cont_idle got %b/%h want 0/f0000002", wen0, wd0);
    end
  endtask

  task automatic test_x0();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hDEAD;
    issue_valid = 1'b1; issue_rd = 5'd3;
    settle();
    n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready got %b want 1", lsu_ready); end
    tick();
    lsu_valid = 1'b0; issue_rd = 5'd0;
    settle();
    n_cmp++; if (wen0 !== 1'b0) begin n_err++; $display("FAIL x0_wen got %b want 0", wen0); end
    n_cmp++; if (busy !== 32'h8) begin n_err++; $display("FAIL x0_busy3 got %h want 00000008", busy); end
    tick();
    issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
    settle();
    n_cmp++; if (busy !== 32'h8) begin n_err++; $display("FAIL x0_issue0 got %h want 00000008", busy); end
    tick();
    lsu_valid = 1'b0;
    settle();
    n_cmp++; if (wen0 !== 1'b1 || waddr0 !== 5'd3 || wd0 !== 32'h33 || busy !== 32'h8) begin
      n_err++; $display("FAIL lsu_wr got %b/%0d/%h busy=%h want 1/3/33 busy=8", wen0, waddr0, wd0, busy);
    end
    tick();
    n_cmp++; if (busy !== 32'h0) begin n_err++; $display("FAIL lsu_clr got %h want 0", busy); end
  endtask

  task automatic test_collision();
    issue_valid = 1'b1; issue_rd = 5'd12;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h1200;
    settle();
    tick();
    lsu_valid = 1'b0;
    settle();
    n_cmp++; if (wen0 !== 1'b1 || waddr0 !== 5'd12) begin
      n_err++; $display("FAIL col_wr got %b/%0d want 1/12", wen0, waddr0);
    end
    tick();
    issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_data = 32'h1201;
    settle();
    n_cmp++; if (busy !== 32'h1000) begin n_err++; $display("FAIL col_set_wins got %h want 00001000", busy); end
    tick();
    lsu_valid = 1'b0;
    tick();
    n_cmp++; if (busy !== 32'h0) begin n_err++; $display("FAIL col_clear got %h want 0", busy); end
  endtask

  task automatic test_full_pop();
    // Keep the LSU busy with x0 results so both FPU entries stay queued.
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0;
    fpu_valid = 1'b1; fpu_rd = 5'd20; fpu_data = 32'hAAAA_0000;
    settle();
    tick();
    fpu_rd = 5'd21; fpu_data = 32'hBBBB_0000;
    settle();
    tick();
    lsu_valid = 1'b0; fpu_valid = 1'b0;
    settle();
    n_cmp++; if (fpu_ready !== 1'b0 || wen0 !== 1'b0) begin
      n_err++; $display("FAIL full_state got ready=%b wen=%b want 0/0", fpu_ready, wen0);
    end
    tick();
    n_cmp++; if (wen0 !== 1'b1 || waddr0 !== 5'd20 || wd0 !== 32'hAAAA_0000) begin
      n_err++; $display("FAIL full_pop1 got %b/%0d/%h want 1/20/aaaa0000", wen0, waddr0, wd0);
    end
    n_cmp++; if (fpu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_back got %b want 1", fpu_ready); end
    tick();
    n_cmp++; if (wen0 !== 1'b1 || waddr0 !== 5'd21 || wd0 !== 32'hBBBB_0000) begin
      n_err++; $display("FAIL full_pop2 got %b/%0d/%h want 1/21/bbbb0000", wen0, waddr0, wd0);
    end
    tick();
    n_cmp++; if (wen0 !== 1'b0) begin n_err++; $display("FAIL full_drained got %b want 0", wen0); end
  endtask

  task automatic test_reset_mid();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0;
    fpu_valid = 1'b1; fpu_rd = 5'd6; fpu_data = 32'h6666;
    settle();
    tick();
    rst = 1'b1; lsu_valid = 1'b0; fpu_valid = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    n_cmp++; if (wen0 !== 1'b0) begin n_err++; $display("FAIL mid_rst_wen got %b want 0", wen0); end
    tick();
    n_cmp++; if (wen0 !== 1'b0) begin n_err++; $display("FAIL mid_rst_discard got %b want 0", wen0); end
  endtask

  initial begin
    test_reset();
    test_single_fpu();
    test_contention();
    test_x0();
    test_collision();
    test_full_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
